// File: rtl/fcs32_chk_par_if.sv
// Beat-stream interface for fcs32_chk_par: data, frame delimiters, byte count,
// expected FCS and the valid/ready handshake.
interface fcs32_chk_par_if #(
    parameter int unsigned DW = 32
);
    localparam int unsigned KW = (DW / 8 > 1) ? $clog2(DW / 8) : 1;

    logic [DW-1:0] data_i;
    logic          sof_i;
    logic          eof_i;
    logic [KW-1:0] kcnt_i;
    logic [31:0]   exp_i;
    logic          vld_i;
    logic          rdy_o;

    modport master (
        output data_i, sof_i, eof_i, kcnt_i, exp_i, vld_i,
        input  rdy_o
    );

    modport slave (
        input  data_i, sof_i, eof_i, kcnt_i, exp_i, vld_i,
        output rdy_o
    );
endinterface

// File: rtl/fcs32_chk_par.sv
// Parallel FCS32 (Ethernet CRC-32) frame checker, DW bits per beat.
// CRC register runs MSB-first with poly 0x04C11DB7 while each byte is fed
// LSB-first, so the standard FCS is the inverted bit-reversal of the register.
// Results travel through a DLY+1 stage shift pipe to val_o/obs_o/exp_o/err_o.
// Optional feature macro: FCS32_RESIDUE_EN (FCS bytes included in the frame
// data; the raw final CRC is compared against the residue 0xC704DD7B).
module fcs32_chk_par #(
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 31
) (
    input  logic                 bclk_i,
    input  logic                 brst_n_i,
    fcs32_chk_par_if.slave       bus,
    output logic [31:0]          res_o,
    output logic [31:0]          exp_o,
    output logic [31:0]          obs_o,
    output logic                 val_o,
    output logic                 err_o,
    output logic                 abrt_o
);
    localparam int unsigned NB      = DW / 8;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] ONES    = 32'hFFFFFFFF;
`ifdef FCS32_RESIDUE_EN
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
`endif

    typedef enum logic [1:0] {StIdle, StFrame, StFinal} state_e;

    typedef struct packed {
        logic        val;
        logic [31:0] obs;
        logic [31:0] exp;
    } stage_t;

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        abrt_q, abrt_d;
`ifndef FCS32_RESIDUE_EN
    logic [31:0] exp_q, exp_d;
`endif
    stage_t      pipe_q [DLY+1];
    stage_t      pipe_d [DLY+1];

    logic        rdy;
    logic        acc;
    logic        fin;
    int unsigned lanes;
    logic [31:0] seed;
    logic [31:0] beat_crc;
    logic [31:0] obs_val;
    logic [31:0] exp_val;

    // Process the top nbytes lanes, top lane first, bits 0..7 of each byte.
    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [DW-1:0] d,
                                            input int unsigned nbytes);
        logic [31:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int unsigned l = 0; l < NB; l++) begin
            b = d[DW-1-8*l -: 8];
            if (l < nbytes) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    c = (c << 1) ^ ((c[31] ^ b[i]) ? POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    // Transmitted FCS from the raw register: bit-reverse and invert.
    function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = ~c[31-i];
        end
        return r;
    endfunction

    assign rdy       = (state_q != StFinal);
    assign bus.rdy_o = rdy;
    assign acc       = bus.vld_i & rdy;

    // Beat CRC: lane count from kcnt_i on eof only; restart from ONES unless continuing a frame.
    always_comb begin
        lanes = NB;
        if (bus.eof_i && (bus.kcnt_i != '0)) begin
            lanes = 32'(bus.kcnt_i);
        end
        seed     = (state_q == StFrame && !bus.sof_i) ? crc_q : ONES;
        beat_crc = crc_upd(seed, bus.data_i, lanes);
    end

    // Frame FSM next state, CRC accumulation and abort strobe.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        abrt_d  = 1'b0;
        fin     = 1'b0;
`ifndef FCS32_RESIDUE_EN
        exp_d   = exp_q;
`endif
        case (state_q)
            StIdle, StFrame: begin
                if (acc && (bus.sof_i || state_q == StFrame)) begin
                    crc_d  = beat_crc;
                    abrt_d = bus.sof_i && (state_q == StFrame);
                    if (bus.eof_i) begin
                        state_d = StFinal;
`ifndef FCS32_RESIDUE_EN
                        exp_d   = bus.exp_i;
`endif
                    end else begin
                        state_d = StFrame;
                    end
                end
            end
            StFinal: begin
                state_d = StIdle;
                fin     = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Result values entering the alignment pipe.
    always_comb begin
`ifdef FCS32_RESIDUE_EN
        obs_val = crc_q;
        exp_val = RESIDUE;
`else
        obs_val = fcs32_brev(crc_q);
        exp_val = exp_q;
`endif
    end

    // Alignment pipe: stage 0 loads on FINAL, later stages shift every cycle.
    always_comb begin
        pipe_d[0].val = fin;
        pipe_d[0].obs = fin ? obs_val : 32'h0;
        pipe_d[0].exp = fin ? exp_val : 32'h0;
        for (int unsigned i = 1; i <= DLY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State, CRC and pipe registers.
    always_ff @(posedge bclk_i or negedge brst_n_i) begin
        if (!brst_n_i) begin
            state_q <= StIdle;
            crc_q   <= 32'h0;
            abrt_q  <= 1'b0;
`ifndef FCS32_RESIDUE_EN
            exp_q   <= 32'h0;
`endif
            for (int unsigned i = 0; i <= DLY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            abrt_q  <= abrt_d;
`ifndef FCS32_RESIDUE_EN
            exp_q   <= exp_d;
`endif
            for (int unsigned i = 0; i <= DLY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign res_o  = crc_q;
    assign val_o  = pipe_q[DLY].val;
    assign obs_o  = pipe_q[DLY].obs;
    assign exp_o  = pipe_q[DLY].exp;
    assign err_o  = pipe_q[DLY].val && (pipe_q[DLY].obs != pipe_q[DLY].exp);
    assign abrt_o = abrt_q;
endmodule

// File: tb/tb_fcs32_chk_par.sv
// Scoreboard bench for fcs32_chk_par: a DW=32/DLY=31 instance and a DW=8/DLY=0 instance.
module tb_fcs32_chk_par;
    localparam int DLY = 31;

    typedef struct {
        logic [31:0] obs;
        logic [31:0] exp;
        logic        err;
        int          cyc;
    } res_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_chk;
    int          n_err;
    int          last_waits;
    int          first_waits;
    bit          in_frame;
    res_t        q[$];
    res_t        q8[$];
    int          aq[$];

    logic [31:0] res, expo, obs, res8, expo8, obs8;
    logic        val, err, abrt, val8, err8, abrt8;

    fcs32_chk_par_if #(.DW(32)) bus32 ();
    fcs32_chk_par_if #(.DW(8))  bus8 ();

    fcs32_chk_par #(.DW(32), .DLY(DLY)) u_dut (
        .bclk_i   (clk),
        .brst_n_i (rst_n),
        .bus      (bus32),
        .res_o    (res),
        .exp_o    (expo),
        .obs_o    (obs),
        .val_o    (val),
        .err_o    (err),
        .abrt_o   (abrt)
    );

    fcs32_chk_par #(.DW(8), .DLY(0)) u_dut8 (
        .bclk_i   (clk),
        .brst_n_i (rst_n),
        .bus      (bus8),
        .res_o    (res8),
        .exp_o    (expo8),
        .obs_o    (obs8),
        .val_o    (val8),
        .err_o    (err8),
        .abrt_o   (abrt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 32-bit instance: results and abort strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (val) begin
                if (q.size() == 0) begin
                    chk("unexpected_val", 32'(val), 32'd0);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("val_cycle", 32'(cyc), 32'(e.cyc));
                    chk("obs_o", obs, e.obs);
                    chk("exp_o", expo, e.exp);
                    chk("err_o", 32'(err), 32'(e.err));
                end
            end
            if (abrt) begin
                if (aq.size() == 0) begin
                    chk("unexpected_abrt", 32'(abrt), 32'd0);
                end else begin
                    chk("abrt_cycle", 32'(cyc), 32'(aq.pop_front()));
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (val8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_val8", 32'(val8), 32'd0);
                end else begin
                    res_t e;
                    e = q8.pop_front();
                    chk("val8_cycle", 32'(cyc), 32'(e.cyc));
                    chk("obs8_o", obs8, e.obs);
                    chk("exp8_o", expo8, e.exp);
                    chk("err8_o", 32'(err8), 32'(e.err));
                end
            end
            if (abrt8) chk("unexpected_abrt8", 32'(abrt8), 32'd0);
        end
    end

    task automatic idle(input int n);
        @(negedge clk);
        bus32.vld_i = 1'b0;
        bus8.vld_i  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sof, input bit eof,
                             input logic [1:0] kc, input logic [31:0] expv,
                             input logic [31:0] obsv);
        int w;
        int k;
        @(negedge clk);
        bus32.data_i = d;
        bus32.sof_i  = sof;
        bus32.eof_i  = eof;
        bus32.kcnt_i = kc;
        bus32.exp_i  = expv;
        bus32.vld_i  = 1'b1;
        w = 0;
        while (!bus32.rdy_o && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w == 8) chk("rdy_timeout", 32'(w), 32'd0);
        last_waits = w;
        k = cyc;
        if (sof && in_frame) aq.push_back(k + 1);
        if (sof || in_frame) begin
            if (eof) begin
                q.push_back('{obs: obsv, exp: expv, err: (expv != obsv), cyc: k + 2 + DLY});
                in_frame = 1'b0;
            end else begin
                in_frame = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    // Split a string into 32-bit beats, top lane first; pad lanes carry 0xA5.
    task automatic send_frame(input string s, input logic [31:0] expv, input logic [31:0] obsv);
        int n;
        int nb;
        logic [31:0] w;
        logic [7:0]  b;
        logic [1:0]  kc;
        n  = s.len();
        nb = (n + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 4; j++) begin
                b = (4 * bi + j < n) ? s[4*bi+j] : 8'hA5;
                w[31-8*j -: 8] = b;
            end
            kc = (bi == nb - 1) ? 2'(n % 4) : 2'($urandom_range(0, 3));
            send_beat(w, bi == 0, bi == nb - 1, kc, expv, obsv);
            if (bi == 0) first_waits = last_waits;
        end
    endtask

    task automatic send8_frame(input string s, input logic [31:0] expv, input logic [31:0] obsv);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus8.data_i = s[i];
            bus8.sof_i  = (i == 0);
            bus8.eof_i  = (i == s.len() - 1);
            bus8.kcnt_i = 1'b0;
            bus8.exp_i  = expv;
            bus8.vld_i  = 1'b1;
            w = 0;
            while (!bus8.rdy_o && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (w == 8) chk("rdy8_timeout", 32'(w), 32'd0);
            if (i == s.len() - 1) begin
                q8.push_back('{obs: obsv, exp: expv, err: (expv != obsv), cyc: cyc + 2});
            end
            @(posedge clk);
        end
    endtask

    // Asynchronous reset away from the clock edge; in-flight results are dropped.
    task automatic do_reset();
        @(negedge clk);
        bus32.vld_i = 1'b0;
        bus8.vld_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_res_o", res, 32'h0);
        chk("rst_obs_o", obs, 32'h0);
        chk("rst_exp_o", expo, 32'h0);
        chk("rst_flags", {28'h0, val, err, abrt, bus32.rdy_o}, 32'h1);
        q.delete();
        aq.delete();
        q8.delete();
        in_frame = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        cyc         = 0;
        in_frame    = 1'b0;
        last_waits  = 0;
        first_waits = 0;
        bus32.data_i = '0; bus32.sof_i = 1'b0; bus32.eof_i = 1'b0;
        bus32.kcnt_i = '0; bus32.exp_i = '0;   bus32.vld_i = 1'b0;
        bus8.data_i  = '0; bus8.sof_i  = 1'b0; bus8.eof_i  = 1'b0;
        bus8.kcnt_i  = '0; bus8.exp_i  = '0;   bus8.vld_i  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_res_o", res, 32'h0);
        chk("reset_flags", {28'h0, val, err, abrt, bus32.rdy_o}, 32'h1);
        chk("reset_rdy8", 32'(bus8.rdy_o), 32'd1);
        rst_n = 1'b1;

        // A beat without sof while idle is ignored.
        send_beat(32'h31323334, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        idle(2);
        chk("idle_beat_res_o", res, 32'h0);

        send_frame("123456789", 32'hCBF43926, 32'hCBF43926);
        chk("rdy_idle_waits", 32'(first_waits), 32'd0);
        idle(3);
        send_frame("123456789", 32'hCBF43927, 32'hCBF43926);
        idle(2);
        send_beat(32'h00ABCDEF, 1'b1, 1'b1, 2'd1, 32'hD202EF8D, 32'hD202EF8D);
        idle(2);
        send_frame("abc", 32'h352441C2, 32'h352441C2);
        idle(1);
        send_frame("a", 32'h00000000, 32'hE8B7BE43);
        idle(1);
        send_beat(32'h00000000, 1'b1, 1'b1, 2'd0, 32'h2144DF1C, 32'h2144DF1C);
        idle(1);
        send_frame("The quick brown fox jumps over the lazy dog", 32'h414FA339, 32'h414FA339);
        idle(2);

        // Second sof inside a frame aborts the first one.
        send_beat(32'h11223344, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
        send_beat(32'h55667788, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
        send_frame("123456789", 32'hCBF43926, 32'hCBF43926);
        idle(2);

        // Back-to-back frames with vld_i held high.
        send_frame("a", 32'hE8B7BE43, 32'hE8B7BE43);
        send_frame("abc", 32'h352441C2, 32'h352441C2);
        chk("b2b_rdy_low_cycles", 32'(first_waits), 32'd1);
        send_beat(32'h00000000, 1'b1, 1'b1, 2'd0, 32'h2144DF1C, 32'h2144DF1C);
        chk("b2b3_rdy_low_cycles", 32'(last_waits), 32'd1);
        idle(DLY + 6);

        // Reset with results in flight, then reset mid-frame.
        send_frame("abc", 32'h352441C2, 32'h352441C2);
        idle(5);
        do_reset();
        idle(DLY + 5);
        send_beat(32'h31323334, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
        send_beat(32'h35363738, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        do_reset();
        send_frame("123456789", 32'hCBF43926, 32'hCBF43926);
        idle(DLY + 6);

        // Byte-wide instance with no alignment delay.
        send8_frame("123456789", 32'hCBF43926, 32'hCBF43926);
        send8_frame("a", 32'hE8B7BE42, 32'hE8B7BE43);
        idle(6);

        chk("pending_results", 32'(q.size()), 32'd0);
        chk("pending_aborts", 32'(aq.size()), 32'd0);
        chk("pending_results8", 32'(q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
